multicycle_ctrl: RTL and testbench

Control FSM for the multicycle RV32I datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the IR, PC, register-file, ALU and memory strobes, and handshakes with the instruction and data memories. Decodes the same opcode set as the immediate generator: LOAD, OP-IMM, STORE, BRANCH and OP. Any other opcode raises a sticky trap.

---
 rtl/multicycle_ctrl_if.sv | 20 ++
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multicycle control FSM and the
// instruction/data memories.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  instr, imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output instr, imem_ack, dmem_ack
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, with a sticky trap for bad opcodes/timeouts.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master mem,
  input  logic             branch_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             alu_src_imm,
  output logic [1:0]       alu_op,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [6:0]         opcode;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               trap_q;
  logic [CNT_W-1:0]   instret_q;

  logic imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, pc_src_c;
  logic reg_we_c, wb_sel_c, alu_src_imm_c;
  logic [1:0] alu_op_c;
  logic wait_expired;
  logic opcode_legal;
  logic unused_instr_hi;

  assign wait_expired    = (wait_cnt == WAIT_LAST);
  assign opcode_legal    = (opcode == OPC_LOAD)   || (opcode == OPC_OPIMM) ||
                           (opcode == OPC_STORE)  || (opcode == OPC_BRANCH) ||
                           (opcode == OPC_OP);
  assign unused_instr_hi = ^mem.instr[31:7];

  // ALU setup is held through WB so the writeback sees a stable result.
  always_comb begin
    state_nxt     = state;
    imem_req_c    = 1'b0;
    dmem_req_c    = 1'b0;
    dmem_we_c     = 1'b0;
    ir_we_c       = 1'b0;
    pc_we_c       = 1'b0;
    pc_src_c      = 1'b0;
    reg_we_c      = 1'b0;
    wb_sel_c      = 1'b0;
    alu_src_imm_c = 1'b0;
    alu_op_c      = 2'b00;
    case (state)
      FETCH: begin
        imem_req_c = 1'b1;
        if (mem.imem_ack) begin
          ir_we_c   = 1'b1;
          state_nxt = DECODE;
        end else if (wait_expired) begin
          state_nxt = TRAP;
        end
      end
      DECODE: state_nxt = opcode_legal ? EXEC : TRAP;
      EXEC: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: begin
            alu_src_imm_c = 1'b1;
            state_nxt     = MEM;
          end
          OPC_OPIMM: begin
            alu_src_imm_c = 1'b1;
            alu_op_c      = 2'b10;
            state_nxt     = WB;
          end
          OPC_OP: begin
            alu_op_c  = 2'b10;
            state_nxt = WB;
          end
          OPC_BRANCH: begin
            alu_op_c  = 2'b01;
            pc_we_c   = 1'b1;
            pc_src_c  = branch_taken;
            state_nxt = FETCH;
          end
          default: state_nxt = TRAP;
        endcase
      end
      MEM: begin
        dmem_req_c    = 1'b1;
        dmem_we_c     = (opcode == OPC_STORE);
        alu_src_imm_c = 1'b1;
        if (mem.dmem_ack) begin
          if (opcode == OPC_STORE) begin
            pc_we_c   = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end else if (wait_expired) begin
          state_nxt = TRAP;
        end
      end
      WB: begin
        reg_we_c      = 1'b1;
        wb_sel_c      = (opcode == OPC_LOAD);
        pc_we_c       = 1'b1;
        alu_src_imm_c = (opcode != OPC_OP);
        alu_op_c      = (opcode == OPC_LOAD) ? 2'b00 : 2'b10;
        state_nxt     = FETCH;
      end
      TRAP: state_nxt = TRAP;
      default: state_nxt = TRAP;
    endcase
    if (!rst_n) begin
      imem_req_c    = 1'b0;
      dmem_req_c    = 1'b0;
      dmem_we_c     = 1'b0;
      ir_we_c       = 1'b0;
      pc_we_c       = 1'b0;
      pc_src_c      = 1'b0;
      reg_we_c      = 1'b0;
      wb_sel_c      = 1'b0;
      alu_src_imm_c = 1'b0;
      alu_op_c      = 2'b00;
    end
  end

  // Wait counter restarts on every state change; it only ticks while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      opcode    <= '0;
      wait_cnt  <= '0;
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && mem.imem_ack)
        opcode <= mem.instr[6:0];
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (state == FETCH || state == MEM)
        wait_cnt <= wait_cnt + 1'b1;
      if (state_nxt == TRAP)
        trap_q <= 1'b1;
      if (pc_we_c)
        instret_q <= instret_q + 1'b1;
    end
  end

  assign mem.imem_req = imem_req_c;
  assign mem.dmem_req = dmem_req_c;
  assign mem.dmem_we  = dmem_we_c;
  assign ir_we        = ir_we_c;
  assign pc_we        = pc_we_c;
  assign pc_src       = pc_src_c;
  assign reg_we       = reg_we_c;
  assign wb_sel       = wb_sel_c;
  assign alu_src_imm  = alu_src_imm_c;
  assign alu_op       = alu_op_c;
  assign trap         = trap_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues expected strobe
// snapshots with their cycle index; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  typedef struct {
    int          at;
    logic [10:0] s;
    logic [31:0] ir;
    string       name;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic        ir_we, pc_we, pc_src, reg_we, wb_sel, alu_src_imm, trap;
  logic [1:0]  alu_op;
  logic [31:0] instret;

  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  ev_t exp_q[$];

  multicycle_ctrl_if mem_if();

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mem_if), .branch_taken(branch_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
    .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] mk(input logic imr, input logic dr, input logic dw,
                                     input logic irw, input logic pw, input logic ps,
                                     input logic rw, input logic ws, input logic asi,
                                     input logic [1:0] aop);
    return {imr, dr, dw, irw, pw, ps, rw, ws, asi, aop};
  endfunction

  logic [10:0] strobes;
  assign strobes = {mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, ir_we, pc_we,
                    pc_src, reg_we, wb_sel, alu_src_imm, alu_op};

  logic [10:0] F_ACK, EX_ADDR, EX_OPIMM, EX_OP, WB_OPIMM, WB_OP, MEM_LD, WB_LD, ST_ACK, BR_T, BR_N;
  initial begin
    F_ACK    = mk(1,0,0,1,0,0,0,0,0,2'b00);
    EX_ADDR  = mk(0,0,0,0,0,0,0,0,1,2'b00);
    EX_OPIMM = mk(0,0,0,0,0,0,0,0,1,2'b10);
    EX_OP    = mk(0,0,0,0,0,0,0,0,0,2'b10);
    WB_OPIMM = mk(0,0,0,0,1,0,1,0,1,2'b10);
    WB_OP    = mk(0,0,0,0,1,0,1,0,0,2'b10);
    MEM_LD   = mk(0,1,0,0,0,0,0,0,1,2'b00);
    WB_LD    = mk(0,0,0,0,1,0,1,1,1,2'b00);
    ST_ACK   = mk(0,1,1,0,1,0,0,0,1,2'b00);
    BR_T     = mk(0,0,0,0,1,1,0,0,0,2'b01);
    BR_N     = mk(0,0,0,0,1,0,0,0,0,2'b01);
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic expect_event(input int at, input logic [10:0] s, input logic [31:0] ir, input string nm);
    ev_t e;
    e.at = at; e.s = s; e.ir = ir; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic ia, input logic [31:0] ins, input logic da, input logic bt);
    mem_if.imem_ack = ia;
    mem_if.instr    = ins;
    mem_if.dmem_ack = da;
    branch_taken    = bt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    mem_if.instr    = 32'h0;
    branch_taken    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_strobes", {21'h0, strobes}, 32'h0);
    checkOutput("reset_trap", {31'h0, trap}, 32'h0);
    checkOutput("reset_instret", instret, 32'h0);
    rst_n = 1'b1;
  endtask

  // Every cycle carrying a strobe beyond a bare imem_req is an event.
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
    end else begin
      if (|{mem_if.dmem_req, ir_we, pc_we, reg_we, alu_src_imm, alu_op}) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_event: got at=%0d strobes=%b instret=%0d, expected no event",
                   cyc, strobes, instret);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.at == cyc && e.s === strobes && e.ir === instret) n_pass++;
          else $display("[TB] FAIL %s: got at=%0d strobes=%b instret=%0d, expected at=%0d strobes=%b instret=%0d",
                        e.name, cyc, strobes, instret, e.at, e.s, e.ir);
        end
      end
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_req;
    int first_trap;

    // ADDI then ADD with imem_ack held high
    do_reset();
    expect_event(0, F_ACK, 0, "addi_fetch");
    expect_event(2, EX_OPIMM, 0, "addi_exec");
    expect_event(3, WB_OPIMM, 0, "addi_wb");
    expect_event(4, F_ACK, 1, "add_fetch");
    expect_event(6, EX_OP, 1, "add_exec");
    expect_event(7, WB_OP, 1, "add_wb");
    repeat (4) applyStimulus(1, I_ADDI, 0, 0);
    checkOutput("addi_instret", instret, 1);
    repeat (4) applyStimulus(1, I_ADD, 0, 0);
    mem_if.imem_ack = 1'b0;
    checkOutput("add_instret", instret, 2);
    checkOutput("seg1_drained", exp_q.size(), 0);

    // LW with 3-cycle dmem wait; stray acks in other states ignored
    do_reset();
    expect_event(0, F_ACK, 0, "lw_fetch");
    expect_event(2, EX_ADDR, 0, "lw_exec");
    for (int k = 3; k <= 6; k++) expect_event(k, MEM_LD, 0, "lw_mem");
    expect_event(7, WB_LD, 0, "lw_wb");
    applyStimulus(1, I_LW, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("lw_instret", instret, 1);
    checkOutput("seg2_drained", exp_q.size(), 0);

    // SW, BEQ taken, BEQ not taken, then illegal opcode
    do_reset();
    expect_event(0, F_ACK, 0, "sw_fetch");
    expect_event(2, EX_ADDR, 0, "sw_exec");
    expect_event(3, ST_ACK, 0, "sw_mem");
    expect_event(4, F_ACK, 1, "beq_fetch");
    expect_event(6, BR_T, 1, "beq_taken");
    expect_event(7, F_ACK, 2, "beq2_fetch");
    expect_event(9, BR_N, 2, "beq_not_taken");
    expect_event(10, F_ACK, 3, "ill_fetch");
    applyStimulus(1, I_SW, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, I_BEQ, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, I_BEQ, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("branch_instret", instret, 3);
    applyStimulus(1, I_ILL, 0, 0);
    mem_if.imem_ack = 1'b1;
    mem_if.dmem_ack = 1'b1;
    #1;
    checkOutput("trap_in_decode", {31'h0, trap}, 0);
    @(posedge clk);
    #1;
    checkOutput("trap_set", {31'h0, trap}, 1);
    repeat (20) applyStimulus(1, I_ADDI, 1, 1);
    checkOutput("trap_sticky", {31'h0, trap}, 1);
    checkOutput("trap_instret", instret, 3);
    checkOutput("trap_no_req", {31'h0, mem_if.imem_req}, 0);
    checkOutput("seg3_drained", exp_q.size(), 0);

    // imem_ack withheld: 16 request cycles then trap
    do_reset();
    mem_if.imem_ack = 1'b0;
    n_req = 0;
    first_trap = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_if.imem_req) n_req++;
      if (trap && first_trap < 0) first_trap = i;
      @(posedge clk);
    end
    #1;
    checkOutput("timeout_req_cycles", n_req, 16);
    checkOutput("timeout_trap_cycle", first_trap, 16);

    // ack on the 16th waiting cycle is still accepted
    do_reset();
    expect_event(15, F_ACK, 0, "late_fetch");
    expect_event(17, EX_OPIMM, 0, "late_exec");
    expect_event(18, WB_OPIMM, 0, "late_wb");
    repeat (15) applyStimulus(0, 0, 0, 0);
    applyStimulus(1, I_ADDI, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput("late_ack_no_trap", {31'h0, trap}, 0);
    checkOutput("late_ack_instret", instret, 1);

    // dmem_ack withheld in MEM
    do_reset();
    expect_event(0, F_ACK, 0, "lwto_fetch");
    expect_event(2, EX_ADDR, 0, "lwto_exec");
    for (int k = 3; k <= 18; k++) expect_event(k, MEM_LD, 0, "lwto_mem");
    applyStimulus(1, I_LW, 0, 0);
    repeat (19) applyStimulus(0, 0, 0, 0);
    checkOutput("dmem_timeout_trap", {31'h0, trap}, 1);
    checkOutput("dmem_timeout_instret", instret, 0);

    // reset pulled during MEM of a LW
    do_reset();
    expect_event(0, F_ACK, 0, "abort_fetch");
    expect_event(2, EX_ADDR, 0, "abort_exec");
    expect_event(3, MEM_LD, 0, "abort_mem");
    applyStimulus(1, I_LW, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    rst_n = 1'b0;
    mem_if.dmem_ack = 1'b1;
    #1;
    checkOutput("abort_strobes_zero", {21'h0, strobes}, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_instret", instret, 0);
    rst_n = 1'b1;
    mem_if.dmem_ack = 1'b0;
    #1;
    checkOutput("abort_restart_req", {31'h0, mem_if.imem_req}, 1);
    checkOutput("abort_restart_trap", {31'h0, trap}, 0);
    @(posedge clk);
    #1;
    checkOutput("seg6_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
